// File: rtl/psum_row_buf_if.sv
// Psum row buffer bus: producer stream in, committed full-width row out.
// The master side drives Vld/Psum/FnhRow/Ack; the slave side is the buffer.
interface psum_row_buf_if #(
  parameter int unsigned PSUM_WIDTH = 23,
  parameter int unsigned LENPSUM    = 16,
  parameter int unsigned CNT_W      = $clog2(LENPSUM) + 1
);
  logic                          CNVPSB_Vld;
  logic [PSUM_WIDTH-1:0]         CNVPSB_Psum;
  logic                          CNVPSB_FnhRow;
  logic                          PSBCNV_Rdy;
  logic                          PSBOUT_Vld;
  logic [PSUM_WIDTH*LENPSUM-1:0] PSBOUT_Psum;
  logic [CNT_W-1:0]              PSBOUT_Cnt;
  logic                          PSBOUT_Ack;
  logic                          PSBOUT_Err;

  modport master (
    output CNVPSB_Vld, CNVPSB_Psum, CNVPSB_FnhRow, PSBOUT_Ack,
    input  PSBCNV_Rdy, PSBOUT_Vld, PSBOUT_Psum, PSBOUT_Cnt, PSBOUT_Err
  );

  modport slave (
    input  CNVPSB_Vld, CNVPSB_Psum, CNVPSB_FnhRow, PSBOUT_Ack,
    output PSBCNV_Rdy, PSBOUT_Vld, PSBOUT_Psum, PSBOUT_Cnt, PSBOUT_Err
  );
endinterface

// File: rtl/psum_row_buf.sv
// Double-buffered psum row collector: one bank fills from the serial psum
// stream while the other presents a committed row until it is acknowledged.
module psum_row_buf #(
  parameter int unsigned PSUM_WIDTH = 23,
  parameter int unsigned LENPSUM    = 16,
  parameter int unsigned CNT_W      = $clog2(LENPSUM) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  psum_row_buf_if.slave bus
);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILL,
    BANK_FULL
  } bank_state_e;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LENPSUM);

  logic [PSUM_WIDTH-1:0] mem_q   [2][LENPSUM];
  logic [PSUM_WIDTH-1:0] mem_d   [2][LENPSUM];
  logic [CNT_W-1:0]      cnt_q   [2];
  logic [CNT_W-1:0]      cnt_d   [2];
  bank_state_e           state_q [2];
  bank_state_e           state_d [2];
  logic                  wsel_q, wsel_d;
  logic                  rsel_q, rsel_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      wptr_q, wptr_d;
  logic                  wr_full, rd_full, wr_ok;

  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    err_d   = err_q;
    wptr_d  = wptr_q;

    // Gating on the registered bank state means an Ack freeing the write bank
    // this cycle does not rescue a Vld arriving in the same cycle.
    wr_full = (state_q[wsel_q] == BANK_FULL);
    rd_full = (state_q[rsel_q] == BANK_FULL);
    wr_ok   = bus.CNVPSB_Vld && !wr_full && (wptr_q < LEN_C);

    if (bus.CNVPSB_Vld && !wr_ok) begin
      err_d = 1'b1;
    end

    if (wr_ok) begin
      for (int unsigned i = 0; i < LENPSUM; i++) begin
        if (wptr_q == CNT_W'(i)) begin
          mem_d[wsel_q][i] = bus.CNVPSB_Psum;
        end
      end
      wptr_d = wptr_q + 1'b1;
      if (state_q[wsel_q] == BANK_EMPTY) begin
        state_d[wsel_q] = BANK_FILL;
      end
    end

    if (bus.CNVPSB_FnhRow) begin
      if (wr_full) begin
        err_d = 1'b1;
      end else begin
        state_d[wsel_q] = BANK_FULL;
        cnt_d[wsel_q]   = wptr_q + CNT_W'(wr_ok);
        wptr_d          = '0;
        wsel_d          = ~wsel_q;
      end
    end

    // A FULL read bank is never the bank being written, so release cannot
    // collide with the write/commit updates above.
    if (bus.PSBOUT_Ack && rd_full) begin
      for (int unsigned i = 0; i < LENPSUM; i++) begin
        mem_d[rsel_q][i] = '0;
      end
      cnt_d[rsel_q]   = '0;
      state_d[rsel_q] = BANK_EMPTY;
      rsel_d          = ~rsel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < LENPSUM; i++) begin
          mem_q[b][i] <= '0;
        end
        cnt_q[b]   <= '0;
        state_q[b] <= BANK_EMPTY;
      end
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      err_q  <= 1'b0;
      wptr_q <= '0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      err_q   <= err_d;
      wptr_q  <= wptr_d;
    end
  end

  always_comb begin
    bus.PSBOUT_Psum = '0;
    for (int unsigned i = 0; i < LENPSUM; i++) begin
      bus.PSBOUT_Psum[i*PSUM_WIDTH +: PSUM_WIDTH] = mem_q[rsel_q][i];
    end
  end

  assign bus.PSBOUT_Vld = (state_q[rsel_q] == BANK_FULL);
  assign bus.PSBOUT_Cnt = cnt_q[rsel_q];
  assign bus.PSBCNV_Rdy = (state_q[wsel_q] != BANK_FULL);
  assign bus.PSBOUT_Err = err_q;

endmodule

// File: tb/tb_psum_row_buf.sv
// Bench for psum_row_buf: per-cycle vector table for handshake outputs plus a
// row scoreboard that is loaded on commit and drained on each released row.
module tb_psum_row_buf;
  localparam int unsigned PW = 23;
  localparam int unsigned L  = 4;
  localparam int unsigned CW = 3;

  typedef logic [PW*L-1:0] row_t;

  typedef struct {
    logic          rst;
    logic          vld;
    logic [PW-1:0] psum;
    logic          fnh;
    logic          ack;
    logic          e_vld;
    logic          e_rdy;
    logic          e_err;
    logic [CW-1:0] e_cnt;
    logic          zchk;
    logic          push;
    logic [CW-1:0] r_cnt;
    row_t          r_data;
  } vec_t;

  typedef struct {
    logic [CW-1:0] cnt;
    row_t          data;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  vec_t vecs[$];
  sb_t  sb[$];

  psum_row_buf_if #(.PSUM_WIDTH(PW), .LENPSUM(L), .CNT_W(CW)) bus ();

  psum_row_buf #(.PSUM_WIDTH(PW), .LENPSUM(L), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic row_t row4(input int unsigned a, input int unsigned b,
                                input int unsigned c, input int unsigned d);
    return {PW'(d), PW'(c), PW'(b), PW'(a)};
  endfunction

  function automatic vec_t mk(input logic rst, input logic vld, input int unsigned psum,
                              input logic fnh, input logic ack,
                              input logic ev, input logic er, input logic ee,
                              input int unsigned ec, input logic zc,
                              input logic push = 1'b0, input int unsigned rc = 0,
                              input row_t rd = '0);
    vec_t v;
    v.rst = rst; v.vld = vld; v.psum = PW'(psum); v.fnh = fnh; v.ack = ack;
    v.e_vld = ev; v.e_rdy = er; v.e_err = ee; v.e_cnt = CW'(ec); v.zchk = zc;
    v.push = push; v.r_cnt = CW'(rc); v.r_data = rd;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input row_t got, input row_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, got, want);
    end
  endtask

  initial begin
    vec_t v;
    sb_t  e;
    logic prev_vld = 1'b0;

    bus.CNVPSB_Vld    = 1'b0;
    bus.CNVPSB_Psum   = '0;
    bus.CNVPSB_FnhRow = 1'b0;
    bus.PSBOUT_Ack    = 1'b0;

    //               rst vld psum fnh ack  vld rdy err cnt zchk  push rcnt row
    vecs.push_back(mk(1, 0,  0, 0, 0,  0, 1, 0, 0, 1));
    // basic fill, FnhRow on the last Vld
    vecs.push_back(mk(0, 1,  5, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  6, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  7, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  8, 1, 0,  1, 1, 0, 4, 0,  1, 4, row4(5, 6, 7, 8)));
    vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 0, 0, 1));
    // short row, FnhRow alone
    vecs.push_back(mk(0, 1,  9, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 10, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0,  1, 1, 0, 2, 0,  1, 2, row4(9, 10, 0, 0)));
    vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 0, 0, 1));
    // ping-pong: both banks full, drop, Ack-frees-bank drop, back-to-back Ack
    vecs.push_back(mk(0, 1, 11, 1, 0,  1, 1, 0, 1, 0,  1, 1, row4(11, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 12, 0, 0,  1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 13, 1, 0,  1, 0, 0, 1, 0,  1, 2, row4(12, 13, 0, 0)));
    vecs.push_back(mk(0, 1,  3, 0, 0,  1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 99, 0, 1,  1, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 20, 1, 0,  1, 1, 1, 1, 0,  1, 1, row4(20, 0, 0, 0)));
    vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0,  0, 0, 0,  0, 1, 0, 0, 1));
    // overflow: fifth Vld dropped
    vecs.push_back(mk(0, 1,  1, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  2, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  3, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  4, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  5, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0, 1, 0,  1, 1, 1, 4, 0,  1, 4, row4(1, 2, 3, 4)));
    vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 1, 0, 1));
    // empty row, then FnhRow and Ack in the same cycle
    vecs.push_back(mk(0, 0,  0, 1, 0,  1, 1, 1, 0, 1,  1, 0, row4(0, 0, 0, 0)));
    vecs.push_back(mk(0, 1,  7, 0, 0,  1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1,  8, 1, 1,  1, 1, 1, 2, 0,  1, 2, row4(7, 8, 0, 0)));
    vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 1, 0, 1));
    // reset mid-row, then a clean full row
    vecs.push_back(mk(0, 1,  1, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1,  2, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0,  0, 0, 0,  0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 30, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 31, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 33, 1, 0,  1, 1, 0, 4, 0,  1, 4, row4(30, 31, 32, 33)));
    vecs.push_back(mk(0, 0,  0, 0, 1,  0, 1, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst_n             = !v.rst;
      bus.CNVPSB_Vld    = v.vld;
      bus.CNVPSB_Psum   = v.psum;
      bus.CNVPSB_FnhRow = v.fnh;
      bus.PSBOUT_Ack    = v.ack;
      if (v.push) sb.push_back('{cnt: v.r_cnt, data: v.r_data});
      if (v.ack && prev_vld) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty vec=%0d got=release want=queued_row", i);
        end else begin
          e = sb.pop_front();
          check("row_data", i, bus.PSBOUT_Psum, e.data);
          check("row_cnt", i, row_t'(bus.PSBOUT_Cnt), row_t'(e.cnt));
        end
      end
      @(posedge clk);
      #1;
      check("vld", i, row_t'(bus.PSBOUT_Vld), row_t'(v.e_vld));
      check("rdy", i, row_t'(bus.PSBCNV_Rdy), row_t'(v.e_rdy));
      check("err", i, row_t'(bus.PSBOUT_Err), row_t'(v.e_err));
      check("cnt", i, row_t'(bus.PSBOUT_Cnt), row_t'(v.e_cnt));
      if (v.zchk) check("psum_zero", i, bus.PSBOUT_Psum, '0);
      prev_vld = v.e_vld;
    end

    check("sb_drained", vecs.size(), row_t'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
